inst_sram_resp: RTL and testbench

Responder end of the CPU's `inst_sram_*` port: a single-port synchronous SRAM model with MIPS kseg0/kseg1 address translation, per-byte write enables, and a configurable access latency. A fetch stage drives en/wen/addr/wdata. This block returns `sram_rdata` and, for latencies above one, raises `stallreq` toward the stall controller so the requester holds its address. The same block also serves the data SRAM port in simulation and FPGA builds.

---
 rtl/sram_pkg.sv | 33 +++
 rtl/inst_sram_resp_if.sv | 41 ++++
 rtl/sram_array.sv | 37 +++
 rtl/inst_sram_resp.sv | 126 ++++++++++++
 tb/tb_inst_sram_resp.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types, constants and address helpers for the
//               instruction/data SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Responder FSM: waiting for a request, or counting out access latency
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Strips the segment bits of a kseg0/kseg1 virtual address
    localparam logic [31:0] KSEG_MASK          = 32'h1fff_ffff;

    // Physical byte address of word 0 (MIPS reset vector region)
    localparam logic [31:0] DEFAULT_BASE_PADDR = 32'h1fc0_0000;

    // Largest supported access latency and the counter width it needs
    localparam int          MAX_LATENCY        = 4;
    localparam int          CNT_W              = 3;

    // kseg0/kseg1 (addr[31:30] == 2'b10) map to the low 512 MB physical;
    // every other segment passes through untranslated.
    function automatic logic [31:0] kseg_translate(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_sram_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_resp_if
// Description : inst_sram_* style request/response bundle between a fetch
//               (or memory) stage and the SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_sram_resp_if;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stallreq;
    logic        addr_err;

    // Requester side (CPU pipeline stage)
    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata,
        input  stallreq,
        input  addr_err
    );

    // Responder side (this SRAM model)
    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata,
        output stallreq,
        output addr_err
    );

endinterface
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_array
// Description : 2^ADDR_W x 32 single-port storage with four byte-lane write
//               enables and a registered (synchronous) read port. Not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array #(
    parameter int ADDR_W = 14
) (
    input  wire logic              clk,
    input  wire logic              rd_en,
    input  wire logic [3:0]        wr_be,
    input  wire logic [ADDR_W-1:0] idx,
    input  wire logic [31:0]       wdata,
    output logic      [31:0]       rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    // Byte-lane writes and synchronous read; the read register holds between reads
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            r_q <= r_mem[idx];
        end
    end

    assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/inst_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_resp
// Description : Responder for the CPU inst_sram_* port. Translates kseg0/kseg1
//               addresses, checks alignment/range, and performs byte-lane
//               writes or reads after LATENCY cycles, stalling the requester
//               while a multi-cycle access is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sram_resp
    import sram_pkg::*;
#(
    parameter int          ADDR_W     = 14,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_PADDR = DEFAULT_BASE_PADDR
) (
    input  wire logic        clk,
    input  wire logic        rst,
    inst_sram_resp_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LATENCY - 1);
    localparam logic             C_MULTI = (LATENCY > 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_wen;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_rd_vis;
    logic               r_addr_err;

    logic               w_busy;
    logic [3:0]         w_wen;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [31:0]        w_paddr;
    logic [31:0]        w_off;
    logic               w_valid;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_done;
    logic               w_is_read;
    logic [31:0]        w_q;

    // While BUSY the latched request is authoritative; live inputs are ignored
    assign w_busy    = (r_state == BUSY);
    assign w_wen     = w_busy ? r_wen   : bus.sram_wen;
    assign w_addr    = w_busy ? r_addr  : bus.sram_addr;
    assign w_wdata   = w_busy ? r_wdata : bus.sram_wdata;

    // Wrap-around offset from the base; anything past the array is out of range
    assign w_paddr   = kseg_translate(w_addr);
    assign w_off     = w_paddr - BASE_PADDR;
    assign w_valid   = (w_addr[1:0] == 2'b00) && ((w_off >> (ADDR_W + 2)) == 32'd0);
    assign w_idx     = w_off[ADDR_W+1:2];
    assign w_is_read = (w_wen == 4'b0000);

    // The edge ending this cycle completes an access
    assign w_done    = w_busy ? (r_cnt == C_LAST) : (bus.sram_en && !C_MULTI);

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .rd_en  (w_done && w_is_read && w_valid),
        .wr_be  ((w_done && w_valid) ? w_wen : 4'b0000),
        .idx    (w_idx),
        .wdata  (w_wdata),
        .rdata  (w_q)
    );

    // Stall spans the request cycle through the cycle before completion;
    // gated by rst so it drops immediately when reset hits mid-access.
    assign bus.stallreq   = !rst && (w_busy ? (r_cnt < C_LAST)
                                            : (bus.sram_en && C_MULTI));

    // Invalid reads and reset present zero; writes leave the visible word alone
    assign bus.sram_rdata = r_rd_vis ? w_q : 32'd0;
    assign bus.addr_err   = r_addr_err;

    // Request FSM: latch and count for multi-cycle latency, record completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wen      <= 4'b0000;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd_vis   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.sram_en && C_MULTI) begin
                        r_wen   <= bus.sram_wen;
                        r_addr  <= bus.sram_addr;
                        r_wdata <= bus.sram_wdata;
                        r_cnt   <= CNT_W'(1);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            if (w_done) begin
                r_addr_err <= !w_valid;
                if (w_is_read) begin
                    r_rd_vis <= w_valid;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sram_resp
// Description : Self-checking bench for inst_sram_resp at latencies 1, 3, 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sram_resp;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    inst_sram_resp_if if1 ();
    inst_sram_resp_if if3 ();
    inst_sram_resp_if if4 ();

    inst_sram_resp #(.ADDR_W(14), .LATENCY(1), .BASE_PADDR(32'h1fc0_0000)) dut1 (
        .clk(clk), .rst(rst_a), .bus(if1.slave));
    inst_sram_resp #(.ADDR_W(8), .LATENCY(3), .BASE_PADDR(32'h1fc0_0000)) dut3 (
        .clk(clk), .rst(rst_a), .bus(if3.slave));
    inst_sram_resp #(.ADDR_W(8), .LATENCY(4), .BASE_PADDR(32'h1fc0_0000)) dut4 (
        .clk(clk), .rst(rst_b), .bus(if4.slave));

    int total = 0;
    int bad   = 0;

    // Reference state for the LATENCY=1 instance
    logic [31:0] m1 [int];
    logic [31:0] e_rdata;
    logic        e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Address mapping from the segment rules, in plain arithmetic
    function automatic bit map_addr(input logic [31:0] a, input int aw, output int idx);
        logic [31:0] phys;
        logic [31:0] off;
        if (a >= 32'ha000_0000 && a < 32'hc000_0000)      phys = a - 32'ha000_0000;
        else if (a >= 32'h8000_0000 && a < 32'ha000_0000) phys = a - 32'h8000_0000;
        else                                              phys = a;
        off = phys - 32'h1fc0_0000;
        idx = int'(off / 4);
        return (a % 4 == 0) && ((off / 4) < (32'd1 << aw));
    endfunction

    // One LATENCY=1 cycle: drive, check no stall, clock, check against the model
    task automatic op1(input logic en, input logic [3:0] wen, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        int idx;
        bit ok;
        if1.sram_en = en; if1.sram_wen = wen; if1.sram_addr = a; if1.sram_wdata = wd;
        #1;
        chk({tag, "/stall"}, {31'b0, if1.stallreq}, 32'd0);
        @(posedge clk); #1;
        if (en) begin
            ok    = map_addr(a, 14, idx);
            e_err = !ok;
            if (wen == 4'b0000) begin
                e_rdata = ok ? m1[idx] : 32'd0;
            end else if (ok) begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) m1[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if1.sram_en = 1'b0;
        chk({tag, "/rdata"}, if1.sram_rdata, e_rdata);
        chk({tag, "/err"},   {31'b0, if1.addr_err}, {31'b0, e_err});
    endtask

    // LATENCY=3 access; address/data are disturbed in the second stall cycle
    task automatic t3(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] old_rd, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
        if3.sram_en = 1'b1; if3.sram_wen = wen; if3.sram_addr = a; if3.sram_wdata = wd;
        #1;
        chk({tag, "/stallN"}, {31'b0, if3.stallreq}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "/stallN1"}, {31'b0, if3.stallreq}, 32'd1);
        chk({tag, "/early"}, if3.sram_rdata, old_rd);
        if3.sram_addr  = 32'hbfc0_0000;
        if3.sram_wdata = ~wd;
        @(posedge clk); #1;
        chk({tag, "/stallN2"}, {31'b0, if3.stallreq}, 32'd0);
        if3.sram_en = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/rdata"}, if3.sram_rdata, exp_rd);
        chk({tag, "/err"}, {31'b0, if3.addr_err}, {31'b0, exp_err});
    endtask

    // LATENCY=4 access with stall profile check
    task automatic t4(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
        if4.sram_en = 1'b1; if4.sram_wen = wen; if4.sram_addr = a; if4.sram_wdata = wd;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk({tag, "/stall"}, {31'b0, if4.stallreq}, 32'd1);
            @(posedge clk);
        end
        #1;
        chk({tag, "/stallEnd"}, {31'b0, if4.stallreq}, 32'd0);
        if4.sram_en = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/rdata"}, if4.sram_rdata, exp_rd);
        chk({tag, "/err"}, {31'b0, if4.addr_err}, {31'b0, exp_err});
    endtask

    initial begin
        logic [31:0] seg;
        logic [31:0] a;
        int          kind;

        rst_a = 1'b1; rst_b = 1'b1;
        if1.sram_en = 0; if1.sram_wen = 0; if1.sram_addr = 0; if1.sram_wdata = 0;
        if3.sram_en = 0; if3.sram_wen = 0; if3.sram_addr = 0; if3.sram_wdata = 0;
        if4.sram_en = 0; if4.sram_wen = 0; if4.sram_addr = 0; if4.sram_wdata = 0;
        e_rdata = 32'd0; e_err = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst1/rdata", if1.sram_rdata, 32'd0);
        chk("rst1/err",   {31'b0, if1.addr_err}, 32'd0);
        chk("rst1/stall", {31'b0, if1.stallreq}, 32'd0);
        chk("rst3/rdata", if3.sram_rdata, 32'd0);
        chk("rst3/stall", {31'b0, if3.stallreq}, 32'd0);
        chk("rst4/err",   {31'b0, if4.addr_err}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset-vector fetch
        op1(1'b1, 4'hf, 32'hbfc0_0000, 32'h3c08_bfc0, "preload0");
        op1(1'b1, 4'h0, 32'hbfc0_0000, 32'h0,         "fetch0");
        chk("fetch0/const", if1.sram_rdata, 32'h3c08_bfc0);

        // Byte-lane write over a zero word, read via kseg1
        op1(1'b1, 4'hf, 32'hbfc0_0004, 32'h0,         "clr1");
        op1(1'b1, 4'b0101, 32'h9fc0_0004, 32'haabb_ccdd, "lanes");
        op1(1'b1, 4'h0, 32'hbfc0_0004, 32'h0,         "lanesrd");
        chk("lanesrd/const", if1.sram_rdata, 32'h00bb_00dd);

        // Errors: misaligned, one past the end, below the base
        op1(1'b1, 4'h0, 32'hbfc0_0002, 32'h0, "misalign");
        chk("misalign/const", {31'b0, if1.addr_err}, 32'd1);
        op1(1'b1, 4'h0, 32'hbfc0_0000, 32'h0, "refill");
        op1(1'b1, 4'h0, 32'h1fc1_0000, 32'h0, "pastend");
        op1(1'b1, 4'h0, 32'h1fbf_fffc, 32'h0, "below");
        op1(1'b1, 4'hf, 32'hbfc1_0000, 32'hdead_beef, "oorwr");
        op1(1'b1, 4'h0, 32'hbfc0_0000, 32'h0, "oorchk");
        chk("oorchk/const", if1.sram_rdata, 32'h3c08_bfc0);
        op1(1'b0, 4'h0, 32'hbfc0_0002, 32'h0, "idlehold");

        // Randomized traffic over a fully initialised window of 16 words
        for (int i = 0; i < 16; i++)
            op1(1'b1, 4'hf, 32'hbfc0_0000 + 32'(4 * i), $urandom, "init");
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       seg = 32'h9fc0_0000;
                1:       seg = 32'hbfc0_0000;
                default: seg = 32'h1fc0_0000;
            endcase
            a = seg + 32'(4 * $urandom_range(0, 15));
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = seg + 32'h0001_0000 + 32'(4 * $urandom_range(0, 15));
            if (kind == 2) a = seg - 32'd4;
            op1(($urandom_range(0, 7) != 0),
                ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                a, $urandom, "rnd");
        end

        // LATENCY=3: mid-access disturbance must not matter
        t3(4'hf, 32'hbfc0_0014, 32'h1234_5678, 32'd0,         32'd0,         1'b0, "l3wr");
        t3(4'h0, 32'hbfc0_0014, 32'h0,         32'd0,         32'h1234_5678, 1'b0, "l3rd");
        t3(4'h0, 32'hbfc0_0016, 32'h0,         32'h1234_5678, 32'd0,         1'b1, "l3mis");

        // LATENCY=4: seed a word, leave addr_err set, then reset mid-write
        t4(4'hf, 32'hbfc0_0008, 32'hcafe_f00d, 32'd0, 1'b0, "l4wr");
        t4(4'h0, 32'hbfc0_0008, 32'h0, 32'hcafe_f00d, 1'b0, "l4rd");
        t4(4'h0, 32'hbfc0_0009, 32'h0, 32'd0,         1'b1, "l4mis");

        if4.sram_en = 1'b1; if4.sram_wen = 4'hf;
        if4.sram_addr = 32'hbfc0_0008; if4.sram_wdata = 32'hdead_beef;
        #1;
        chk("l4rst/stallN", {31'b0, if4.stallreq}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("l4rst/stallN2", {31'b0, if4.stallreq}, 32'd1);
        rst_b = 1'b1; if4.sram_en = 1'b0;
        #1;
        chk("l4rst/stallAsync", {31'b0, if4.stallreq}, 32'd0);
        chk("l4rst/errAsync",   {31'b0, if4.addr_err}, 32'd0);
        #2;
        rst_b = 1'b0;
        @(posedge clk); #1;
        t4(4'h0, 32'hbfc0_0008, 32'h0, 32'hcafe_f00d, 1'b0, "l4after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
